// File: rtl/count_up_streamer_pkg.sv
// Shared definitions for the count_up_streamer traffic source.
package count_up_streamer_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : count_up_streamer_pkg

// File: rtl/count_up_streamer.sv
// AXI-Stream-style source emitting repeating frames 0 .. count_up_to-1,
// flagging the final beat of each frame with count_last.
module count_up_streamer
  import count_up_streamer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             counter_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_up_to,
  output logic [WIDTH-1:0] count_up,
  output logic             count_valid,
  input  logic             count_ready,
  output logic             count_last
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] eff_limit;
  logic             last_beat;
  logic             xfer;

  // A zero limit behaves as a one-beat frame so the last beat is always reachable.
  assign eff_limit = (limit_q == '0) ? WIDTH'(1) : limit_q;
  assign last_beat = (state_q == RUN) && (cnt_q == (eff_limit - WIDTH'(1)));
  // An X ready falls into the not-taken branch below, i.e. it stalls.
  assign xfer      = vld_q && count_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    limit_d = limit_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        limit_d = count_up_to;
        cnt_d   = '0;
        vld_d   = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (xfer) begin
          if (last_beat) begin
            cnt_d   = '0;
            limit_d = count_up_to;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge counter_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      limit_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      vld_q   <= vld_d;
    end
  end

  assign count_up    = cnt_q;
  assign count_valid = vld_q;
  assign count_last  = last_beat;

endmodule : count_up_streamer

// File: tb/tb_count_up_streamer.sv
// Directed bench for count_up_streamer: framing, stalls, limit resampling, reset.
module tb_count_up_streamer;

  localparam int W = 32;

  logic         counter_clk;
  logic         reset;
  logic [W-1:0] count_up_to;
  logic [W-1:0] count_up;
  logic         count_valid;
  logic         count_ready;
  logic         count_last;

  int compared;
  int mismatched;

  count_up_streamer #(.WIDTH(W)) dut (
    .counter_clk (counter_clk),
    .reset       (reset),
    .count_up_to (count_up_to),
    .count_up    (count_up),
    .count_valid (count_valid),
    .count_ready (count_ready),
    .count_last  (count_last)
  );

  initial counter_clk = 1'b0;
  always #5 counter_clk = ~counter_clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge counter_clk);
    #1;
  endtask

  // Check n consecutive beats starting at value start, with last expected at lastval.
  task automatic run_beats(input int start, input int n, input int lastval);
    for (int k = 0; k < n; k++) begin
      chk("beat_valid", W'(count_valid), W'(1));
      chk("beat_value", count_up, W'(start + k));
      chk("beat_last", W'(count_last), W'((start + k) == lastval));
      step();
    end
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    reset       = 1'b1;
    count_ready = 1'b0;
    count_up_to = W'(20);

    #1;
    chk("rst_valid", W'(count_valid), W'(0));
    chk("rst_value", count_up, W'(0));
    chk("rst_last", W'(count_last), W'(0));

    #5 reset = 1'b0;
    step();
    chk("start_valid", W'(count_valid), W'(1));
    chk("start_value", count_up, W'(0));
    chk("start_last", W'(count_last), W'(0));

    repeat (3) step();
    chk("noready_valid", W'(count_valid), W'(1));
    chk("noready_value", count_up, W'(0));

    #40 count_ready = 1'b1;

    // Frame 1: full 20-beat frame.
    run_beats(0, 20, 19);

    // Frame 2: stall at 5, then shrink the limit mid-frame.
    run_beats(0, 5, 19);
    count_ready = 1'b0;
    step();
    step();
    chk("stall_value", count_up, W'(5));
    chk("stall_last", W'(count_last), W'(0));
    chk("stall_valid", W'(count_valid), W'(1));
    count_ready = 1'b1;
    run_beats(5, 5, 19);
    count_up_to = W'(5);
    run_beats(10, 10, 19);

    // Frame 3: 0..4; a mid-frame change to 0 must not shorten it.
    run_beats(0, 2, 4);
    count_up_to = W'(0);
    run_beats(2, 3, 4);

    // Zero-length limit: single-beat frames.
    repeat (3) run_beats(0, 1, 0);
    count_up_to = W'(1);
    repeat (3) run_beats(0, 1, 0);

    // Back to 20-beat frames, then reset mid-frame at value 7.
    count_up_to = W'(20);
    run_beats(0, 1, 0);
    run_beats(0, 7, 19);
    chk("pre_rst_value", count_up, W'(7));
    reset = 1'b1;
    #1;
    chk("async_rst_valid", W'(count_valid), W'(0));
    chk("async_rst_value", count_up, W'(0));
    chk("async_rst_last", W'(count_last), W'(0));
    #2 reset = 1'b0;
    step();
    chk("restart_valid", W'(count_valid), W'(1));
    chk("restart_value", count_up, W'(0));
    step();
    chk("restart_next", count_up, W'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_count_up_streamer
